// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl: run-time controller for the clock-divider/tick path.
// Holds the active divisor, sequences start/stop/step, emits clk_out + tick.
//
// Ports:
//   clk_in      in   1   system clock, all logic on posedge
//   rst         in   1   asynchronous active-high reset
//   start       in   1   pulse: begin continuous running
//   stop        in   1   pulse: finish current period, then halt
//   step        in   1   pulse: run exactly one period while stopped
//   cfg_valid   in   1   new divisor offered
//   cfg_divisor in   32  requested divisor (unsigned)
//   cfg_ready   out  1   no divisor update pending
//   cfg_clamped out  1   pulse: accepted divisor was clamped to MIN_DIVISOR
//   clk_out     out  1   registered 50% divided square wave
//   tick        out  1   registered one-cycle pulse per completed period
//   running     out  1   controller is not STOPPED
//   div_active  out  32  divisor currently in force
module clock_divider_ctrl #(
  parameter logic [31:0] DEFAULT_DIVISOR = 32'd100000000,
  parameter logic [31:0] MIN_DIVISOR     = 32'd2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_divisor,
  output logic        cfg_ready,
  output logic        cfg_clamped,
  output logic        clk_out,
  output logic        tick,
  output logic        running,
  output logic [31:0] div_active
);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_STEPPING,
    ST_STOPPING
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_cnt;
  logic [31:0] r_div;
  logic [31:0] r_pend_div;
  logic        r_pend;
  logic        r_applied;
  logic        r_clk;
  logic        r_tick;
  logic        r_clamped;

  logic        w_active;
  logic        w_wrap;
  logic        w_accept;
  logic        w_apply;
  logic        w_low;

  assign w_active = (r_state != ST_STOPPED);
  assign w_wrap   = w_active && (r_cnt == (r_div - 32'd1));
  assign w_accept = cfg_valid && !r_pend;
  assign w_low    = (cfg_divisor < MIN_DIVISOR);

  // While running, a new divisor only lands on a period boundary so that
  // no half-period is ever cut short or stretched.
  assign w_apply  = r_pend && !r_applied && (w_active ? w_wrap : 1'b1);

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_STOPPED: begin
        if (start)
          w_next = ST_RUNNING;
        else if (step)
          w_next = ST_STEPPING;
      end
      ST_RUNNING: begin
        if (stop)
          w_next = ST_STOPPING;
      end
      ST_STEPPING: begin
        if (w_wrap)
          w_next = ST_STOPPED;
        else if (stop)
          w_next = ST_STOPPING;
        else if (start)
          w_next = ST_RUNNING;
      end
      ST_STOPPING: begin
        if (w_wrap)
          w_next = ST_STOPPED;
        else if (start)
          w_next = ST_RUNNING;
      end
      default: w_next = ST_STOPPED;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      r_state <= ST_STOPPED;
    else
      r_state <= w_next;
  end

  // Period counter; sits at 0 while stopped so every run starts cleanly
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)
      r_cnt <= 32'd0;
    else if (!w_active || w_wrap)
      r_cnt <= 32'd0;
    else
      r_cnt <= r_cnt + 32'd1;
  end

  // Output registers (one cycle behind the counter)
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_clk  <= w_active && (r_cnt < (r_div >> 1));
      r_tick <= w_wrap;
    end
  end

  // Divisor handshake: accept -> pending -> apply -> release one cycle later
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_div      <= DEFAULT_DIVISOR;
      r_pend_div <= DEFAULT_DIVISOR;
      r_pend     <= 1'b0;
      r_applied  <= 1'b0;
      r_clamped  <= 1'b0;
    end else begin
      r_clamped <= w_accept && w_low;
      if (w_accept) begin
        r_pend     <= 1'b1;
        r_pend_div <= w_low ? MIN_DIVISOR : cfg_divisor;
      end else if (r_applied) begin
        r_pend    <= 1'b0;
        r_applied <= 1'b0;
      end else if (w_apply) begin
        r_div     <= r_pend_div;
        r_applied <= 1'b1;
      end
    end
  end

  assign cfg_ready   = !r_pend;
  assign cfg_clamped = r_clamped;
  assign clk_out     = r_clk;
  assign tick        = r_tick;
  assign running     = w_active;
  assign div_active  = r_div;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb_clock_divider_ctrl: directed bench for clock_divider_ctrl.
// Runs with DEFAULT_DIVISOR=4; expected values are hand-derived.
module tb_clock_divider_ctrl;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_divisor = 32'd0;
  logic        cfg_ready;
  logic        cfg_clamped;
  logic        clk_out;
  logic        tick;
  logic        running;
  logic [31:0] div_active;

  int n_chk  = 0;
  int n_fail = 0;

  clock_divider_ctrl #(
    .DEFAULT_DIVISOR(32'd4),
    .MIN_DIVISOR    (32'd2)
  ) u_dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .cfg_valid  (cfg_valid),
    .cfg_divisor(cfg_divisor),
    .cfg_ready  (cfg_ready),
    .cfg_clamped(cfg_clamped),
    .clk_out    (clk_out),
    .tick       (tick),
    .running    (running),
    .div_active (div_active)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  int e2c[6] = '{1, 1, 1, 0, 0, 0};
  int e2t[6] = '{0, 0, 0, 0, 0, 1};
  int e4c[5] = '{1, 1, 0, 0, 0};
  int e4t[5] = '{0, 0, 0, 0, 1};
  int e4r[5] = '{1, 1, 1, 1, 0};

  initial begin
    int w;
    // Reset values
    cyc();
    cyc();
    chk("rst_clk", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_run", running, 0);
    chk("rst_rdy", cfg_ready, 1);
    chk("rst_clamp", cfg_clamped, 0);
    chk("rst_div", div_active, 4);
    rst = 1'b0;
    cyc();
    chk("rel_run", running, 0);
    chk("rel_clk", clk_out, 0);

    // 1: start at D=4 -> 1,1,0,0 with tick on last 0
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t1_run", running, 1);
    chk("t1_clk1", clk_out, 0);
    for (int k = 2; k <= 9; k++) begin
      int p;
      cyc();
      p = (k - 2) % 4;
      chk($sformatf("t1_clk%0d", k), clk_out, (p < 2) ? 1 : 0);
      chk($sformatf("t1_tick%0d", k), tick, (p == 3) ? 1 : 0);
    end

    // 3: stop at counter=1 -> period completes, one tick, then halt
    cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t3_run_a", running, 1);
    chk("t3_clk_a", clk_out, 1);
    cyc();
    chk("t3_clk_b", clk_out, 0);
    chk("t3_tick_b", tick, 0);
    cyc();
    chk("t3_tick_c", tick, 1);
    chk("t3_run_c", running, 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("t3_idle_tick%0d", k), tick, 0);
      chk($sformatf("t3_idle_clk%0d", k), clk_out, 0);
    end
    // start and step together: start wins, runs continuously
    start = 1'b1;
    step = 1'b1;
    cyc();
    start = 1'b0;
    step = 1'b0;
    chk("t3_restart", running, 1);
    for (int k = 2; k <= 9; k++) begin
      int p;
      cyc();
      p = (k - 2) % 4;
      chk($sformatf("t3_clk%0d", k), clk_out, (p < 2) ? 1 : 0);
      chk($sformatf("t3_tick%0d", k), tick, (p == 3) ? 1 : 0);
    end
    chk("t3_still_run", running, 1);

    // 2: offer 6 at counter=1; change lands at the next boundary
    cyc();
    chk("t2_rdy0", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_divisor = 32'd6;
    cyc();
    cfg_valid = 1'b0;
    chk("t2_rdy_a", cfg_ready, 0);
    chk("t2_clk_a", clk_out, 1);
    chk("t2_div_a", div_active, 4);
    cyc();
    chk("t2_rdy_b", cfg_ready, 0);
    chk("t2_clk_b", clk_out, 0);
    cyc();
    chk("t2_rdy_c", cfg_ready, 0);
    chk("t2_tick_c", tick, 1);
    chk("t2_div_c", div_active, 6);
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk($sformatf("t2_clk%0d", k), clk_out, e2c[k]);
      chk($sformatf("t2_tick%0d", k), tick, e2t[k]);
    end
    chk("t2_rdy_end", cfg_ready, 1);

    // 4: stop, load D=5 while stopped, single step
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    w = 0;
    while (running && w < 20) begin
      cyc();
      w++;
    end
    chk("t4_stopped", running, 0);
    chk("t4_stop_lat", w, 5);
    cfg_valid = 1'b1;
    cfg_divisor = 32'd5;
    cyc();
    cfg_valid = 1'b0;
    chk("t4_rdy_a", cfg_ready, 0);
    chk("t4_div_a", div_active, 6);
    cyc();
    chk("t4_div_b", div_active, 5);
    chk("t4_rdy_b", cfg_ready, 0);
    cyc();
    chk("t4_rdy_c", cfg_ready, 1);
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("t4_run0", running, 1);
    chk("t4_clk0", clk_out, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk($sformatf("t4_clk%0d", k), clk_out, e4c[k]);
      chk($sformatf("t4_tick%0d", k), tick, e4t[k]);
      chk($sformatf("t4_run%0d", k + 1), running, e4r[k]);
    end
    cyc();
    chk("t4_post_run", running, 0);
    chk("t4_post_tick", tick, 0);
    chk("t4_post_clk", clk_out, 0);

    // 5: divisor 1 is clamped to 2
    cfg_valid = 1'b1;
    cfg_divisor = 32'd1;
    cyc();
    cfg_valid = 1'b0;
    chk("t5_clamp_a", cfg_clamped, 1);
    chk("t5_rdy_a", cfg_ready, 0);
    cyc();
    chk("t5_clamp_b", cfg_clamped, 0);
    chk("t5_div", div_active, 2);
    cyc();
    chk("t5_rdy_c", cfg_ready, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("t5_clk%0d", k), clk_out, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("t5_tick%0d", k), tick, (k % 2 == 0) ? 1 : 0);
    end

    // 6: async reset mid-period with a divisor pending
    cfg_valid = 1'b1;
    cfg_divisor = 32'd7;
    cyc();
    cfg_valid = 1'b0;
    chk("t6_pre_clk", clk_out, 1);
    chk("t6_pre_rdy", cfg_ready, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_clk", clk_out, 0);
    chk("t6_tick", tick, 0);
    chk("t6_run", running, 0);
    chk("t6_rdy", cfg_ready, 1);
    chk("t6_div", div_active, 4);
    chk("t6_clamp", cfg_clamped, 0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("t6_post_div%0d", k), div_active, 4);
      chk($sformatf("t6_post_rdy%0d", k), cfg_ready, 1);
      chk($sformatf("t6_post_run%0d", k), running, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
